// File: rtl/trace_feeder_pkg.sv
// ============================================================================
// Module  : trace_feeder_pkg
// Brief   : Shared defaults, state encoding and counter width for trace_feeder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package trace_feeder_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int ISSUED_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/trace_bram.sv
// ============================================================================
// Module  : trace_bram
// Brief   : DEPTH x ADDR_W trace buffer, one write port, one registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_bram #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rdata_q;

  // Array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register only updates on a read, so it holds the last presented word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/trace_feeder.sv
// ============================================================================
// Module  : trace_feeder
// Brief   : Replays a stored address trace to a cache simulator with idle gaps.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_feeder
  import trace_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 16,
  parameter int GAP    = 9,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PTR_W-1:0]    wr_addr,
  input  logic [ADDR_W-1:0]   wr_data,
  input  logic [PTR_W:0]      trace_len,
  input  logic                start,
  output logic [ADDR_W-1:0]   memory_trace,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic                busy,
  output logic                done,
  output logic [ISSUED_W-1:0] issued
);

  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W:0]      len_q, len_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [ISSUED_W-1:0] issued_q, issued_d;
  logic                done_q, done_d;
  logic                last_w;

  assign last_w = ({1'b0, ptr_q} == (len_q - 1'b1));

  trace_bram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_bram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en && (state_q == ST_IDLE) && !rst),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (state_q == ST_FETCH),
    .raddr_i (ptr_q),
    .rdata_o (memory_trace)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    gap_d    = gap_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          issued_d = '0;
          ptr_d    = '0;
          gap_d    = '0;
          if (trace_len != '0) begin
            len_d   = trace_len;
            state_d = ST_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (trace_ready) begin
          if (issued_q != '1) begin
            issued_d = issued_q + 1'b1;
          end
          if (last_w) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
            gap_d = '0;
            state_d = (GAP > 0) ? ST_GAP : ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_FETCH;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign trace_valid = (state_q == ST_PRESENT);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign issued      = issued_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_feeder.sv
// ============================================================================
// Module  : tb_trace_feeder
// Brief   : Directed bench for trace_feeder (GAP=9 and GAP=0 instances).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trace_feeder;

  localparam int AW = 16;
  localparam int DP = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [PW-1:0] wr_addr = '0;
  logic [AW-1:0] wr_data = '0;
  logic [PW:0]   trace_len = '0;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic          ready = 1'b1;

  logic [AW-1:0] mt0, mt1;
  logic          valid0, valid1, busy0, busy1, done0, done1;
  logic [15:0]   issued0, issued1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_v [16];

  always #5 clk = ~clk;

  trace_feeder #(.ADDR_W(AW), .DEPTH(DP), .GAP(9)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
    .trace_len(trace_len), .start(start0), .memory_trace(mt0), .trace_valid(valid0),
    .trace_ready(ready), .busy(busy0), .done(done0), .issued(issued0)
  );

  trace_feeder #(.ADDR_W(AW), .DEPTH(DP), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
    .trace_len(trace_len), .start(start1), .memory_trace(mt1), .trace_valid(valid1),
    .trace_ready(ready), .busy(busy1), .done(done1), .issued(issued1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_mt"},     32'(mt0),     32'h0);
    check_val({tag, "_valid"},  32'(valid0),  32'h0);
    check_val({tag, "_busy"},   32'(busy0),   32'h0);
    check_val({tag, "_done"},   32'(done0),   32'h0);
    check_val({tag, "_issued"}, 32'(issued0), 32'h0);
  endtask

  // Six-entry replay on the GAP=9 instance, optionally stalling entry 2
  // and/or poking start/wr_en/trace_len while busy.
  task automatic run_seq6(input string tag, input bit stall, input bit poke);
    int n, donecnt, donecyc, et;
    logic [15:0] got [6];
    int tim [6];
    n = 0; donecnt = 0; donecyc = -1;
    trace_len = 6; ready = 1'b1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c < 90; c++) begin
      ready   = !(stall && c >= 23 && c <= 27);
      start0  = poke && (c == 5);
      wr_en0  = poke && (c == 5);
      if (poke && c == 5) begin
        wr_addr   = 4'd3;
        wr_data   = 16'hDEAD;
        trace_len = 5'd2;
      end
      if (stall && c >= 23 && c <= 28) begin
        check_val({tag, "_stall_valid"},  32'(valid0),  32'h1);
        check_val({tag, "_stall_mt"},     32'(mt0),     32'h8);
        check_val({tag, "_stall_issued"}, 32'(issued0), 32'h2);
      end
      if (valid0 && ready) begin
        if (n < 6) begin
          got[n] = mt0;
          tim[n] = c;
        end
        n++;
      end
      if (done0) begin
        donecnt++;
        donecyc = c;
      end
      step();
    end
    start0 = 1'b0; wr_en0 = 1'b0; ready = 1'b1;
    check_val({tag, "_ntransfers"}, 32'(n), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < 2)       et = 1 + 11 * k;
      else if (k == 2) et = stall ? 28 : 23;
      else             et = 1 + 11 * k + (stall ? 5 : 0);
      if (k < n) begin
        check_val({tag, "_addr"}, 32'(got[k]), 32'(exp_v[k]));
        check_val({tag, "_time"}, 32'(tim[k]), 32'(et));
      end
    end
    check_val({tag, "_donecnt"}, 32'(donecnt), 32'd1);
    check_val({tag, "_donecyc"}, 32'(donecyc), 32'(57 + (stall ? 5 : 0)));
    check_val({tag, "_issued"},  32'(issued0), 32'd6);
    check_val({tag, "_busy"},    32'(busy0),   32'd0);
  endtask

  initial begin
    exp_v[0] = 16'd0; exp_v[1] = 16'd9; exp_v[2] = 16'd8;
    exp_v[3] = 16'd1; exp_v[4] = 16'd4; exp_v[5] = 16'd5;
    for (int i = 6; i < 16; i++) exp_v[i] = 16'h0100 + 16'(i);

    rst = 1'b1;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1'b1; wr_en1 = 1'b1;
      wr_addr = PW'(i); wr_data = exp_v[i];
      step();
    end
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    step();

    run_seq6("basic", 1'b0, 1'b0);
    run_seq6("stall", 1'b1, 1'b0);

    // Zero-length start: done next cycle, never valid or busy.
    trace_len = 0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_val("len0_done",   32'(done0),   32'h1);
    check_val("len0_busy",   32'(busy0),   32'h0);
    check_val("len0_valid",  32'(valid0),  32'h0);
    check_val("len0_issued", 32'(issued0), 32'h0);
    step();
    check_val("len0_done_off", 32'(done0),  32'h0);
    check_val("len0_valid2",   32'(valid0), 32'h0);

    // Reset after the third transfer, then replay from entry 0.
    trace_len = 6; ready = 1'b1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c < 24; c++) step();
    check_val("prerst_issued", 32'(issued0), 32'd3);
    check_val("prerst_busy",   32'(busy0),   32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("midrst");
    trace_len = 6; start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    check_val("rerun_valid0", 32'(valid0), 32'h1);
    check_val("rerun_mt0",    32'(mt0),    32'h0);
    for (int c = 0; c < 11; c++) step();
    check_val("rerun_valid1", 32'(valid0), 32'h1);
    check_val("rerun_mt1",    32'(mt0),    32'h9);
    for (int c = 0; c < 60; c++) step();
    check_val("rerun_idle", 32'(busy0), 32'h0);

    // start / wr_en / trace_len changes while busy are ignored.
    run_seq6("poke", 1'b0, 1'b1);

    // GAP=0, full-depth replay: one address every two cycles.
    begin
      int n1, dc;
      n1 = 0; dc = -1;
      trace_len = 5'd16; ready = 1'b1; start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (valid1) begin
          if (n1 < 16) begin
            check_val("g0_addr", 32'(mt1), 32'(exp_v[n1]));
            check_val("g0_time", 32'(c),   32'(1 + 2 * n1));
          end
          n1++;
        end
        if (done1) dc = c;
        step();
      end
      check_val("g0_count",  32'(n1),      32'd16);
      check_val("g0_donecyc", 32'(dc),     32'd32);
      check_val("g0_issued", 32'(issued1), 32'd16);
    end

    // Write and start in the same idle cycle: replay sees the new word.
    wr_en0 = 1'b1; wr_addr = 4'd0; wr_data = 16'h00AA;
    trace_len = 5'd1; start0 = 1'b1;
    step();
    wr_en0 = 1'b0; start0 = 1'b0;
    check_val("wrst_busy", 32'(busy0), 32'h1);
    step();
    check_val("wrst_valid", 32'(valid0), 32'h1);
    check_val("wrst_mt",    32'(mt0),    32'hAA);
    step();
    check_val("wrst_done",   32'(done0),   32'h1);
    check_val("wrst_issued", 32'(issued0), 32'h1);
    check_val("wrst_hold",   32'(mt0),     32'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
